// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//
// Multi-cycle instruction sequencer. Walks the datapath through
// FETCH -> DECODE -> EXEC -> WB, owns the program counter and the instruction
// register, handshakes with instruction memory and decodes the IR into the
// ALU / immediate-mux / register-file controls.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   run         start request, only looked at while idle
//   imem_req    fetch request, high for the whole FETCH state
//   imem_addr   fetch address (always equal to pc)
//   imem_ack    fetch complete, imem_rdata valid in the same cycle
//   imem_rdata  instruction word
//   insmsb      IR[31], 1 = immediate-type instruction
//   func        IR[5:0]
//   ALUsrc      1 = ALU B operand from the immediate
//   ALUop       ALU operation code (IR[3:0] while an instruction is in flight)
//   Immsel      immediate-path select
//   regreset    register-file clear, high while idle
//   reg_we      register-file write enable, high for the WB cycle only
//   pc          current program counter
//   halted      HALT instruction has executed
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run; register file held in clear
// FETCH  | imem_req asserted at pc, waiting for imem_ack
// DECODE | IR valid, controls decoded, HALT opcode detected here
// EXEC   | controls stable while the ALU result settles
// WB     | reg_we pulse, pc advances, back to FETCH
// HALT   | HALT opcode retired, frozen until reset

module ctrl_sequencer #(
   parameter int PC_W     = 8,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            insmsb,
   output logic [5:0]      func,
   output logic            ALUsrc,
   output logic [3:0]      ALUop,
   output logic            Immsel,
   output logic            regreset,
   output logic            reg_we,
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [31:0]     HALT_INSTR = 32'h0000_003F;
   localparam logic [PC_W-1:0] PC_RESET   = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_INC     = PC_W'(PC_STEP);

   state_t      state;
   logic [31:0] ir;
   logic        dec_active;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= PC_RESET;
         ir       <= '0;
         imem_req <= 1'b0;
         reg_we   <= 1'b0;
         halted   <= 1'b0;
         regreset <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  regreset <= 1'b0;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  state    <= DECODE;
                  imem_req <= 1'b0;
               end
            end
            DECODE: begin
               if (ir == HALT_INSTR) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               state  <= WB;
               reg_we <= 1'b1;
            end
            WB: begin
               // run is deliberately not re-sampled: the sequence keeps going.
               state    <= FETCH;
               reg_we   <= 1'b0;
               imem_req <= 1'b1;
               pc       <= pc + PC_INC;
            end
            HALT: begin
               imem_req <= 1'b0;
               reg_we   <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               // Illegal encodings recover to a clean idle.
               state    <= IDLE;
               imem_req <= 1'b0;
               reg_we   <= 1'b0;
               halted   <= 1'b0;
               regreset <= 1'b1;
            end
         endcase
      end
   end

   assign imem_addr = pc;

   // Decoded controls only drive the datapath while an instruction is in flight.
   assign dec_active = (state == DECODE) || (state == EXEC) || (state == WB);

   assign insmsb = ir[31];
   assign func   = ir[5:0];
   assign ALUsrc = dec_active & ir[31];
   assign Immsel = dec_active & ir[31];
   assign ALUop  = dec_active ? ir[3:0] : 4'h0;

endmodule
